// File: rtl/multiplier_seq_24x24_pkg.sv
// Shared constants and FSM state type for the sequential 24x24 shift-add multiplier.
// CNT_W must satisfy 2**CNT_W > WIDTH so the counter can hold the iteration count.
package multiplier_seq_24x24_pkg;

    localparam int unsigned WIDTH  = 24;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/multiplier_seq_datapath.sv
// Radix-2 shift-add datapath: operand latch, accumulator, conditional add/shift and sign fix-up.
// Signed operation is compiled in only when MULTIPLIER_SIGNED_EN is defined.
module multiplier_seq_datapath
    import multiplier_seq_24x24_pkg::*;
#(
    parameter int unsigned WIDTH = multiplier_seq_24x24_pkg::WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
`ifdef MULTIPLIER_SIGNED_EN
    input  logic               signed_i,
`endif
    output logic [2*WIDTH-1:0] result_o
);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH:0]   acc_q;
    logic [2*WIDTH:0]   acc_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   a_load;
    logic [WIDTH-1:0]   b_load;

`ifdef MULTIPLIER_SIGNED_EN
    logic neg_q;
    logic neg_d;

    // Magnitudes are taken on load; -2**(WIDTH-1) maps onto itself, which is its magnitude.
    always_comb begin
        a_load = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_load = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
        neg_d  = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            neg_q <= 1'b0;
        end else if (load_i) begin
            neg_q <= neg_d;
        end
    end

    assign result_o = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
`else
    always_comb begin
        a_load = a_i;
        b_load = b_i;
    end

    assign result_o = acc_q[2*WIDTH-1:0];
`endif

    // Upper half plus carry bit absorbs the add; the multiplier lives in the lower half.
    always_comb begin
        sum = acc_q[2*WIDTH:WIDTH];
        if (acc_q[0]) begin
            sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
        end
        acc_d = {sum, acc_q[WIDTH-1:0]} >> 1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q <= '0;
            acc_q   <= '0;
        end else if (load_i) begin
            mcand_q <= a_load;
            acc_q   <= {{(WIDTH + 1){1'b0}}, b_load};
        end else if (step_i) begin
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/multiplier_seq_24x24.sv
// Sequential 24x24 multiplier top: Start/Busy/Done FSM, iteration counter and held product.
// Define MULTIPLIER_SIGNED_EN to add the Signed input for two's-complement operation.
module multiplier_seq_24x24
    import multiplier_seq_24x24_pkg::*;
#(
    parameter int unsigned WIDTH = multiplier_seq_24x24_pkg::WIDTH,
    parameter int unsigned CNT_W = multiplier_seq_24x24_pkg::CNT_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
`ifdef MULTIPLIER_SIGNED_EN
    input  logic               Signed,
`endif
    input  logic [WIDTH-1:0]   HyrjaA,
    input  logic [WIDTH-1:0]   HyrjaB,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Produkti
);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 load;
    logic                 step;
    logic [2*WIDTH-1:0]   result;

    assign load = Start && (state_q != StRun);
    assign step = (state_q == StRun) && (cnt_q != '0);

    multiplier_seq_datapath #(
        .WIDTH    (WIDTH)
    ) u_datapath (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .load_i   (load),
        .step_i   (step),
        .a_i      (HyrjaA),
        .b_i      (HyrjaB),
`ifdef MULTIPLIER_SIGNED_EN
        .signed_i (Signed),
`endif
        .result_o (result)
    );

    // Busy drops with the last iteration; the following RUN cycle commits the product.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Produkti <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (Start) begin
                        state_q <= StRun;
                        cnt_q   <= CNT_W'(WIDTH);
                        Busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            Busy <= 1'b0;
                        end
                    end else begin
                        state_q  <= StDone;
                        Done     <= 1'b1;
                        Produkti <= result;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
